counter_prog: RTL
=================

Name: counter_prog

Overview:
Parametrised programmable modulo counter and tick generator; the next generation of the team's fixed 5-bit terminal-count counter. Adds:
- generic width
- up/down direction
- periodic or one-shot mode
- count enable and synchronous load
- registered wrap pulse and done flag

Used as the timebase and prescaler for the lab datapath and display-scan blocks.

Parameters:
WIDTH, 8, bit width of count, countmax and load_val (legal 2..16)
ONESHOT_DEF, 0, mode latched out of reset when the mode input is unused (tie oneshot to this value)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
en  input  1  count enable; counter holds when low
load  input  1  synchronous load, priority over en
load_val  input  WIDTH  value written to cnt on load
countmax  input  WIDTH  terminal/reload value, sampled every cycle
dir  input  1  0 = up, 1 = down
oneshot  input  1  0 = periodic wrap, 1 = stop at terminal
cnt  output  WIDTH  current count (registered)
out  output  1  combinational terminal flag
tick  output  1  registered one-cycle wrap pulse
done  output  1  registered one-shot completion flag

Behaviour:
- Reset (rst low, async): cnt=0, tick=0, done=0. Outputs take these values immediately, not at the next edge. Deassertion is sampled on the next clk edge.
- Terminal condition (out, combinational from cnt, countmax, dir):
  - up: cnt >= countmax
  - down: cnt == 0
- Per-edge priority:
  1. load: cnt<=load_val, done<=0, tick<=0.
  2. else en=0: cnt, done hold; tick<=0.
  3. else done=1: cnt holds, tick<=0 (one-shot finished).
  4. else counting, as below.
- Up counting:
  - not terminal: cnt<=cnt+1.
  - terminal, periodic: cnt<=0, tick<=1.
  - terminal, one-shot: cnt holds, done<=1, tick<=1.
- Down counting:
  - cnt > countmax: cnt<=countmax (clamp, no tick).
  - else not terminal: cnt<=cnt-1.
  - terminal, periodic: cnt<=countmax, tick<=1.
  - terminal, one-shot: cnt holds at 0, done<=1, tick<=1.
- Period: periodic mode gives one tick per countmax+1 enabled cycles.
- Tick timing: tick is high in the cycle after the wrapping edge, for exactly one cycle. It does not repeat while en is held low.
- Arithmetic: all arithmetic is WIDTH bits, unsigned, no carry out. The up path never exceeds countmax+1 because of the >= test.
- countmax=0:
  - periodic up: terminal every enabled cycle; cnt stays 0 and tick is continuous.
  - periodic down: same.
- countmax changed mid-count: takes effect immediately.
  - up: if cnt is now >= the new value, it wraps on the next enabled edge.
  - down: clamps as above.
- dir or oneshot changed mid-count: takes effect on the next enabled edge, applied to the current cnt. No reset or reload occurs.
- Clearing done: only load or reset clears done. Toggling oneshot does not clear it.
- Reset mid-count overrides everything asynchronously.
- No X propagation: all outputs are defined in every state.

Decomposition:
- Shared package holds:
  - DIR_UP=1'b0, DIR_DOWN=1'b1
  - MODE_PERIODIC=1'b0, MODE_ONESHOT=1'b1
  - default WIDTH constant
- One sub-module is natural: counter_prog_next. It is purely combinational: it takes cnt, countmax, dir and oneshot, and returns next count, terminal flag and wrap flag. counter_prog registers its outputs and applies load/en/done priority.

Test Plan:
1. WIDTH=5, countmax=4, up, periodic, en=1 for 12 cycles after reset -> cnt 0,1,2,3,4,0,1,2,3,4,0,1; out high when cnt=4; tick high in the cycle after each 4->0 edge.
2. countmax=3, down, periodic, load_val=3 then en=1 -> cnt 3,2,1,0,3,2; tick one cycle after each 0->3; out high at cnt=0.
3. countmax=5, up, one-shot, en=1 for 10 cycles -> cnt stops at 5, done=1 from the cycle after reaching 5, single tick. Then load=1, load_val=0 -> done=0 and counting resumes.
4. Up, cnt=7, countmax lowered to 3 mid-count -> next enabled edge cnt=0, tick=1. Repeat in down mode with cnt=7 -> cnt=3, no tick.
5. load and en both high with load_val=9 -> cnt=9 (load wins). en low for 5 cycles -> cnt holds, tick=0. countmax=0 periodic -> tick high every cycle.
6. rst pulled low asynchronously between edges mid-count -> cnt, tick, done go to 0 immediately. After release, counting restarts from 0 on the first enabled edge.

Source files
------------

// File: rtl/counter_prog_pkg.sv
// Shared constants for the programmable modulo counter: direction and mode encodings
// plus the default count width.
package counter_prog_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/counter_prog_next.sv
// Purely combinational next-count logic: terminal detection, wrap/reload and the
// down-count clamp when the count sits above countmax.
module counter_prog_next
  import counter_prog_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] cnt_i,
  input  logic [WIDTH-1:0] countmax_i,
  input  logic             dir_i,
  input  logic             oneshot_i,
  output logic [WIDTH-1:0] cnt_next_o,
  output logic             term_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    cnt_next_o = cnt_i;
    wrap_o     = 1'b0;
    term_o     = (dir_i == DIR_DOWN) ? (cnt_i == '0) : (cnt_i >= countmax_i);

    if (dir_i == DIR_UP) begin
      if (!term_o) begin
        cnt_next_o = cnt_i + One;
      end else begin
        wrap_o = 1'b1;
        if (oneshot_i == MODE_PERIODIC) begin
          cnt_next_o = '0;
        end
      end
    end else begin
      // A count above the new ceiling is pulled down without signalling a wrap.
      if (cnt_i > countmax_i) begin
        cnt_next_o = countmax_i;
      end else if (!term_o) begin
        cnt_next_o = cnt_i - One;
      end else begin
        wrap_o = 1'b1;
        if (oneshot_i == MODE_PERIODIC) begin
          cnt_next_o = countmax_i;
        end
      end
    end
  end

endmodule

// File: rtl/counter_prog.sv
// Programmable up/down modulo counter and tick generator with synchronous load,
// count enable, periodic or one-shot operation, registered tick and done flags.
module counter_prog
  import counter_prog_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEF,
  parameter bit          ONESHOT_DEF = MODE_PERIODIC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] countmax,
  input  logic             dir,
  input  logic             oneshot,
  output logic [WIDTH-1:0] cnt,
  output logic             out,
  output logic             tick,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q, cnt_d, cnt_next;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             term, wrap;

  // ONESHOT_DEF only documents the value oneshot should be tied to when unused.
  logic unused_oneshot_def;
  assign unused_oneshot_def = ONESHOT_DEF;

  counter_prog_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .cnt_i      (cnt_q),
    .countmax_i (countmax),
    .dir_i      (dir),
    .oneshot_i  (oneshot),
    .cnt_next_o (cnt_next),
    .term_o     (term),
    .wrap_o     (wrap)
  );

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    done_d = done_q;
    if (load) begin
      cnt_d  = load_val;
      done_d = 1'b0;
    end else if (en && !done_q) begin
      cnt_d  = cnt_next;
      tick_d = wrap;
      if (wrap && (oneshot == MODE_ONESHOT)) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      done_q <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign out  = term;
  assign tick = tick_q;
  assign done = done_q;

endmodule
